// File: rtl/sha512_pkg.sv
// Shared constants, state encoding and SHA-512 bit functions for the sha512 core.
package sha512_pkg;

  localparam logic [1:0] OP_HASH = 2'b10;
  localparam logic [1:0] OP_READ = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_UPDATE,
    S_READ
  } state_e;

  localparam logic [63:0] K [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  localparam logic [63:0] IV512 [8] = '{
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };

  localparam logic [63:0] IV384 [8] = '{
    64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
    64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4
  };

  function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [63:0] bsig0(input logic [63:0] x);
    return rotr(x, 28) ^ rotr(x, 34) ^ rotr(x, 39);
  endfunction

  function automatic logic [63:0] bsig1(input logic [63:0] x);
    return rotr(x, 14) ^ rotr(x, 18) ^ rotr(x, 41);
  endfunction

  function automatic logic [63:0] ssig0(input logic [63:0] x);
    return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
  endfunction

  function automatic logic [63:0] ssig1(input logic [63:0] x);
    return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
  endfunction

  function automatic logic [63:0] ch(input logic [63:0] e, input logic [63:0] f,
                                     input logic [63:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [63:0] maj(input logic [63:0] a, input logic [63:0] b,
                                      input logic [63:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha512_round.sv
// One combinational SHA-512 round; working variables packed with a at index 0, h at index 7.
module sha512_round
  import sha512_pkg::*;
(
  input  logic [7:0][63:0] st_i,
  input  logic [63:0]      w_i,
  input  logic [63:0]      k_i,
  output logic [7:0][63:0] st_o
);

  logic [63:0] t1;
  logic [63:0] t2;

  always_comb begin
    t1 = st_i[7] + bsig1(st_i[4]) + ch(st_i[4], st_i[5], st_i[6]) + k_i + w_i;
    t2 = bsig0(st_i[0]) + maj(st_i[0], st_i[1], st_i[2]);
    st_o[0] = t1 + t2;
    st_o[1] = st_i[0];
    st_o[2] = st_i[1];
    st_o[3] = st_i[2];
    st_o[4] = st_i[3] + t1;
    st_o[5] = st_i[4];
    st_o[6] = st_i[5];
    st_o[7] = st_i[6];
  end

endmodule

// File: rtl/sha512.sv
// Iterative SHA-384/SHA-512 block core with a 32-bit word-serial command/data interface.
module sha512
  import sha512_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] text_i,
  output logic [31:0] text_o,
  input  logic [3:0]  cmd_i,
  input  logic        cmd_w_i,
  output logic [4:0]  cmd_o
);

  state_e            state_q, state_d;
  logic [3:0]        cmd_q, cmd_d;
  logic              busy_q, busy_d;
  logic [6:0]        cnt_q, cnt_d;
  logic [31:0]       text_q, text_d;
  logic [7:0][63:0]  h_q, h_d, st_q, st_d, st_rnd, h_init;
  logic [15:0][63:0] w_q, w_d;
  logic [63:0]       w_next, h_word, k_t;
  logic [3:0]        widx;
  logic [6:0]        rd_words;

  assign k_t = K[cnt_q];

  sha512_round u_round (
    .st_i (st_q),
    .w_i  (w_q[15]),
    .k_i  (k_t),
    .st_o (st_rnd)
  );

  // w_q[15] always holds W[t]; the new word appended at the bottom is W[t+16].
  assign w_next   = ssig1(w_q[1]) + w_q[6] + ssig0(w_q[14]) + w_q[15];
  assign widx     = 4'(cnt_q - 7'd1);
  assign h_word   = h_q[widx[3:1]];
  assign rd_words = cmd_q[3] ? 7'd16 : 7'd12;

  always_comb begin
    h_init = h_q;
    if (!cmd_i[2]) begin
      for (int unsigned i = 0; i < 8; i++) begin
        h_init[i] = cmd_i[3] ? IV512[i] : IV384[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    text_d  = text_q;
    h_d     = h_q;
    st_d    = st_q;
    w_d     = w_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_w_i) begin
          cmd_d = cmd_i;
          cnt_d = '0;
          if (cmd_i[1:0] == OP_HASH) begin
            state_d = S_LOAD;
            busy_d  = 1'b1;
            h_d     = h_init;
            st_d    = h_init;
          end else if (cmd_i[1:0] == OP_READ) begin
            state_d = S_READ;
            busy_d  = 1'b1;
          end
        end
      end
      S_LOAD: begin
        w_d   = {w_q[15][31:0], w_q[14:0], text_i};
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == 7'd31) begin
          cnt_d   = '0;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        st_d  = st_rnd;
        w_d   = {w_q[14:0], w_next};
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == 7'd79) begin
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        for (int unsigned i = 0; i < 8; i++) begin
          h_d[i] = h_q[i] + st_q[i];
        end
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_READ: begin
        // cnt_q == 0 is the prime edge; word cnt_q-1 is presented afterwards.
        cnt_d = cnt_q + 7'd1;
        if (cnt_q != 7'd0) begin
          text_d = widx[0] ? h_word[31:0] : h_word[63:32];
        end
        if (cnt_q == rd_words) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      text_q  <= '0;
      h_q     <= '0;
      st_q    <= '0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      text_q  <= text_d;
      h_q     <= h_d;
      st_q    <= st_d;
      w_q     <= w_d;
    end
  end

  assign text_o = text_q;
  assign cmd_o  = {busy_q, cmd_q};

endmodule

// File: tb/tb_sha512.sv
// Scoreboard bench for sha512: known-answer digests plus random blocks against a reference model.
module tb_sha512;
  import sha512_pkg::K;
  import sha512_pkg::IV512;
  import sha512_pkg::IV384;

  typedef logic [31:0] blk_t [32];
  typedef struct {
    logic [31:0] w;
    bit          last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] text_i;
  logic [31:0] text_o;
  logic [3:0]  cmd_i;
  logic        cmd_w;
  logic [4:0]  cmd_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] mh [8];
  exp_t        sbq [$];

  logic [31:0] kat384 [16] = '{
    32'h09330c33, 32'hf71147e8, 32'h3d192fc7, 32'h82cd1b47, 32'h53111b17, 32'h3b3b05d2,
    32'h2fa08086, 32'he3b0f712, 32'hfcc7c71a, 32'h557e2db9, 32'h66c3e9fa, 32'h91746039,
    32'h0, 32'h0, 32'h0, 32'h0};
  logic [31:0] kat512 [16] = '{
    32'h8e959b75, 32'hdae313da, 32'h8cf4f728, 32'h14fc143f, 32'h8f7779c6, 32'heb9f7fa1,
    32'h7299aead, 32'hb6889018, 32'h501d289e, 32'h4900f7e4, 32'h331b99de, 32'hc4b5433a,
    32'hc7d329ee, 32'hb6dd2654, 32'h5e96e55b, 32'h874be909};
  logic [31:0] katabc [16] = '{
    32'hddaf35a1, 32'h93617aba, 32'hcc417349, 32'hae204131, 32'h12e6fa4e, 32'h89a97ea2,
    32'h0a9eeee6, 32'h4b55d39a, 32'h2192992a, 32'h274fc1a8, 32'h36ba3c23, 32'ha3feebbd,
    32'h454d4423, 32'h643ce80e, 32'h2a9ac94f, 32'ha54ca49f};

  sha512 dut (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .text_i  (text_i),
    .text_o  (text_o),
    .cmd_i   (cmd_i),
    .cmd_w_i (cmd_w),
    .cmd_o   (cmd_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Textbook compression: full 80-word schedule, then feed-forward into mh.
  task automatic model_hash(input bit mode, input bit cont, input blk_t blk);
    logic [63:0] w [80];
    logic [63:0] v [8];
    logic [63:0] t1, t2;
    if (!cont) for (int i = 0; i < 8; i++) mh[i] = mode ? IV512[i] : IV384[i];
    for (int t = 0; t < 16; t++) w[t] = {blk[2*t], blk[2*t+1]};
    for (int t = 16; t < 80; t++)
      w[t] = (rr(w[t-2], 19) ^ rr(w[t-2], 61) ^ (w[t-2] >> 6)) + w[t-7]
           + (rr(w[t-15], 1) ^ rr(w[t-15], 8) ^ (w[t-15] >> 7)) + w[t-16];
    for (int i = 0; i < 8; i++) v[i] = mh[i];
    for (int t = 0; t < 80; t++) begin
      t1 = v[7] + (rr(v[4], 14) ^ rr(v[4], 18) ^ rr(v[4], 41))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
      t2 = (rr(v[0], 28) ^ rr(v[0], 34) ^ rr(v[0], 39))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) mh[i] = mh[i] + v[i];
  endtask

  function automatic logic [31:0] mword(input int k);
    logic [63:0] h;
    h = mh[k/2];
    return (k % 2 == 1) ? h[31:0] : h[63:32];
  endfunction

  task automatic make_block(input string s, input int bi, output blk_t b);
    int n, total, idx, p;
    logic [127:0] len;
    logic [7:0]   by;
    n     = s.len();
    total = ((n + 17 + 127) / 128) * 128;
    len   = 128'(n) * 128'd8;
    for (int j = 0; j < 32; j++) begin
      b[j] = '0;
      for (int q = 0; q < 4; q++) begin
        idx = bi * 128 + 4 * j + q;
        if (idx < n) by = s[idx];
        else if (idx == n) by = 8'h80;
        else if (idx >= total - 16) begin
          p  = idx - (total - 16);
          by = 8'(len >> (8 * (15 - p)));
        end else by = 8'h00;
        b[j] = {b[j][23:0], by};
      end
    end
  endtask

  task automatic hash_block(input logic [3:0] c, input blk_t blk, input bit poke);
    int cyc;
    bit busy_ok;
    model_hash(c[3], c[2], blk);
    @(negedge clk);
    cmd_i = c;
    cmd_w = 1'b1;
    @(negedge clk);
    cmd_w = 1'b0;
    cyc   = 0;
    check("busy_rise", 64'(cmd_o), 64'({1'b1, c}));
    busy_ok = 1'b1;
    for (int j = 0; j < 32; j++) begin
      text_i = blk[j];
      @(negedge clk);
      cyc++;
      if (!cmd_o[4]) busy_ok = 1'b0;
    end
    text_i = $urandom;
    while (cmd_o[4] && cyc < 140) begin
      if (poke && cyc == 60) begin
        cmd_i = 4'b0001;
        cmd_w = 1'b1;
      end
      @(negedge clk);
      cyc++;
      cmd_w = 1'b0;
      if (poke && cyc == 61) check("cmd_while_busy", 64'(cmd_o), 64'({1'b1, c}));
    end
    check("busy_through_load", 64'(busy_ok), 64'd1);
    n_checks++;
    if (cyc < 113 || cyc > 120) begin
      n_fail++;
      $display("FAIL busy_span: busy fell %0d cycles after command, required 113..120", cyc);
    end
  endtask

  task automatic read_digest(input bit mode, input bit use_kat, input logic [31:0] kat [16]);
    int n, cyc;
    logic [31:0] wv, lastw;
    n = mode ? 16 : 12;
    lastw = '0;
    @(negedge clk);
    cmd_i = {mode, 1'b0, 2'b01};
    cmd_w = 1'b1;
    for (int k = 0; k < n; k++) begin
      wv = use_kat ? kat[k] : mword(k);
      sbq.push_back('{w: wv, last: (k == n - 1)});
      lastw = wv;
    end
    @(negedge clk);
    cmd_w = 1'b0;
    cyc   = 0;
    while (sbq.size() != 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (sbq.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL read_timeout: %0d words never presented, required 0", sbq.size());
      sbq.delete();
    end
    repeat (3) @(negedge clk);
    check("hold_last", 64'(text_o), 64'(lastw));
    check("idle_after_read", 64'(cmd_o[4]), 64'd0);
  endtask

  // Monitor: follows each read from the busy rise, checks the prime edge, then pops words.
  int          rd_phase = 0;
  bit          prev_busy = 1'b0;
  logic [31:0] held;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      rd_phase  = 0;
      prev_busy = 1'b0;
    end else begin
      if (rd_phase == 0) begin
        if (cmd_o[4] && !prev_busy && cmd_o[1:0] == 2'b01) begin
          rd_phase = 1;
          held     = text_o;
        end
      end else if (rd_phase == 1) begin
        check("prime_hold", 64'(text_o), 64'(held));
        rd_phase = 2;
      end else if (sbq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_extra: word %h presented with empty scoreboard, required none", text_o);
        rd_phase = 0;
      end else begin
        e = sbq.pop_front();
        check("rd_word", 64'(text_o), 64'(e.w));
        check("rd_busy", 64'(cmd_o[4]), 64'(!e.last));
        if (e.last) rd_phase = 0;
      end
      prev_busy = cmd_o[4];
    end
  end

  initial begin
    blk_t b1, b2, babc, br;
    logic [31:0] dummy [16];
    bit mode, cont, last_mode;
    string msg;
    msg = "abcdefghbcdefghicdefghijdefghijkefghijklfghijklmghijklmnhijklmnoijklmnopjklmnopqklmnopqrlmnopqrsmnopqrstnopqrstu";
    for (int i = 0; i < 16; i++) dummy[i] = '0;
    for (int i = 0; i < 8; i++) mh[i] = '0;
    make_block(msg, 0, b1);
    make_block(msg, 1, b2);
    make_block("abc", 0, babc);

    rst_n  = 1'b0;
    cmd_w  = 1'b0;
    cmd_i  = '0;
    text_i = '0;
    #12;
    check("reset_text", 64'(text_o), 64'd0);
    check("reset_cmd", 64'(cmd_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    read_digest(1'b1, 1'b0, dummy);

    hash_block(4'b0010, b1, 1'b0);
    hash_block(4'b0110, b2, 1'b0);
    read_digest(1'b0, 1'b1, kat384);

    hash_block(4'b1010, b1, 1'b1);
    hash_block(4'b1110, b2, 1'b0);
    read_digest(1'b1, 1'b1, kat512);

    @(negedge clk);
    cmd_i = 4'b1000;
    cmd_w = 1'b1;
    @(negedge clk);
    cmd_w = 1'b0;
    check("noop_not_busy", 64'(cmd_o[4]), 64'd0);

    hash_block(4'b1010, babc, 1'b0);
    read_digest(1'b1, 1'b1, katabc);

    last_mode = 1'b1;
    for (int it = 0; it < 6; it++) begin
      for (int j = 0; j < 32; j++) br[j] = $urandom;
      cont = ($urandom_range(0, 1) == 1);
      mode = cont ? last_mode : 1'($urandom_range(0, 1));
      hash_block({mode, cont, 2'b10}, br, 1'b0);
      last_mode = mode;
      if ($urandom_range(0, 2) != 0) read_digest(mode, 1'b0, dummy);
    end
    read_digest(last_mode, 1'b0, dummy);

    @(negedge clk);
    cmd_i = 4'b1010;
    cmd_w = 1'b1;
    @(negedge clk);
    cmd_w = 1'b0;
    for (int j = 0; j < 10; j++) begin
      text_i = $urandom;
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    check("midload_rst_text", 64'(text_o), 64'd0);
    check("midload_rst_cmd", 64'(cmd_o), 64'd0);
    for (int i = 0; i < 8; i++) mh[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    read_digest(1'b0, 1'b0, dummy);
    hash_block(4'b1010, babc, 1'b0);
    read_digest(1'b1, 1'b1, katabc);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
